// File: rtl/interrupt_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : interrupt_gen_pkg
// Description : Shared engine package: interrupt FSM state encodings, the
//               interrupt-period reset value and a grant helper.
// Revision    : 1.0 - initial release
// ============================================================================
package interrupt_gen_pkg;

  // One-hot, 8-bit encodings shared with the register decoders.
  typedef enum logic [7:0] {
    ST_IDLE    = 8'b0000_0001,
    ST_ASSERT  = 8'b0000_0010,
    ST_HOLDOFF = 8'b0000_0100
  } irq_state_e;

  // Value the BAR2 decoder loads into its interrupt_period register at reset.
  localparam logic [31:0] c_INTERRUPT_PERIOD_RST = 32'h0003_D090;

  // The core accepts a request when both the request and its grant are low.
  function automatic logic is_grant(input logic req_n, input logic rdy_n);
    return (!req_n) && (!rdy_n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/interrupt_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : interrupt_gen_if
// Description : Bundles the register-decoder, DMA-event and PCIe-core
//               interrupt signals seen by interrupt_gen.
// Revision    : 1.0 - initial release
// ============================================================================
interface interrupt_gen_if;

  logic        interrupts_enabled;
  logic [31:0] interrupt_period;
  logic        irq_event;
  logic        cfg_interrupt_msienable;
  logic        cfg_interrupt_rdy_n;
  logic        cfg_interrupt_n;
  logic        cfg_interrupt_assert_n;
  logic [7:0]  cfg_interrupt_di;
  logic [31:0] irq_count;

  // System side: decoder, DMA engines and PCIe core drive the inputs.
  modport master (
    output interrupts_enabled,
    output interrupt_period,
    output irq_event,
    output cfg_interrupt_msienable,
    output cfg_interrupt_rdy_n,
    input  cfg_interrupt_n,
    input  cfg_interrupt_assert_n,
    input  cfg_interrupt_di,
    input  irq_count
  );

  // Interrupt generator side.
  modport slave (
    input  interrupts_enabled,
    input  interrupt_period,
    input  irq_event,
    input  cfg_interrupt_msienable,
    input  cfg_interrupt_rdy_n,
    output cfg_interrupt_n,
    output cfg_interrupt_assert_n,
    output cfg_interrupt_di,
    output irq_count
  );

endinterface
`default_nettype wire

// File: rtl/interrupt_gen_irq_holdoff_cnt.sv
`default_nettype none
// ============================================================================
// Module      : irq_holdoff_cnt
// Description : Loadable 32-bit down-counter timing the post-grant holdoff.
//               busy while non-zero, done on the final counted cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_holdoff_cnt (
  input  wire logic        trn_clk,
  input  wire logic        reset,
  input  wire logic        load,
  input  wire logic [31:0] load_value,
  output logic             busy,
  output logic             done
);

  logic [31:0] r_count;

  // Load on grant, otherwise count down to zero and stop there.
  always_ff @(posedge trn_clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_value;
    end else if (r_count != 32'd0) begin
      r_count <= r_count - 32'd1;
    end
  end

  assign busy = (r_count != 32'd0);
  assign done = (r_count == 32'd1);

endmodule
`default_nettype wire

// File: rtl/interrupt_gen.sv
`default_nettype none
// ============================================================================
// Module      : interrupt_gen
// Description : Coalescing MSI interrupt generator. DMA events set a pending
//               flag; one request is raised to the PCIe core, held until
//               granted, then further requests are held off for
//               interrupt_period cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module interrupt_gen
  import interrupt_gen_pkg::*;
#(
  parameter logic [7:0] MSI_VECTOR = 8'h00
) (
  input  wire logic         trn_clk,
  input  wire logic         reset,
  interrupt_gen_if.slave    bus
);

  irq_state_e  r_state;
  logic        r_pending;
  logic        r_cfg_interrupt_n;
  logic [31:0] r_irq_count;

  logic        w_grant;
  logic        w_fire;
  logic        w_hold_busy;
  logic        w_hold_done;

  // r_cfg_interrupt_n is low only in ST_ASSERT, so this is the ASSERT grant.
  assign w_grant = is_grant(r_cfg_interrupt_n, bus.cfg_interrupt_rdy_n);

  // An event in the same cycle counts as pending for the IDLE decision.
  assign w_fire = (r_pending || bus.irq_event) &&
                  bus.interrupts_enabled && bus.cfg_interrupt_msienable;

  irq_holdoff_cnt u_holdoff (
    .trn_clk    (trn_clk),
    .reset      (reset),
    .load       (w_grant),
    .load_value (bus.interrupt_period),
    .busy       (w_hold_busy),
    .done       (w_hold_done)
  );

  // Request FSM with registered active-low request output.
  always_ff @(posedge trn_clk or posedge reset) begin
    if (reset) begin
      r_state           <= ST_IDLE;
      r_cfg_interrupt_n <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_fire) begin
            r_state           <= ST_ASSERT;
            r_cfg_interrupt_n <= 1'b0;
          end
        end
        ST_ASSERT: begin
          // Enables are ignored here: once raised, the request waits for grant.
          if (w_grant) begin
            r_cfg_interrupt_n <= 1'b1;
            r_state           <= (bus.interrupt_period == 32'd0) ? ST_IDLE : ST_HOLDOFF;
          end
        end
        ST_HOLDOFF: begin
          if (w_hold_done || !w_hold_busy) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state           <= ST_IDLE;
          r_cfg_interrupt_n <= 1'b1;
        end
      endcase
    end
  end

  // Pending flag: set by any event, cleared by a grant without a new event.
  always_ff @(posedge trn_clk or posedge reset) begin
    if (reset) begin
      r_pending <= 1'b0;
    end else if (bus.irq_event) begin
      r_pending <= 1'b1;
    end else if (w_grant) begin
      r_pending <= 1'b0;
    end
  end

  // Granted-interrupt counter, wraps naturally at 32 bits.
  always_ff @(posedge trn_clk or posedge reset) begin
    if (reset) begin
      r_irq_count <= '0;
    end else if (w_grant) begin
      r_irq_count <= r_irq_count + 32'd1;
    end
  end

  assign bus.cfg_interrupt_n        = r_cfg_interrupt_n;
  assign bus.cfg_interrupt_assert_n = 1'b1;
  assign bus.cfg_interrupt_di       = MSI_VECTOR;
  assign bus.irq_count              = r_irq_count;

endmodule
`default_nettype wire

// File: tb/tb_interrupt_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_interrupt_gen
// Description : Self-checking bench for interrupt_gen: directed scenarios and
//               random traffic against a behavioural model, compared through
//               a per-cycle scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_interrupt_gen;
  import interrupt_gen_pkg::*;

  localparam logic [7:0] TB_VECTOR = 8'h5C;

  logic trn_clk = 1'b0;
  logic reset   = 1'b1;

  interrupt_gen_if bus ();

  interrupt_gen #(
    .MSI_VECTOR (TB_VECTOR)
  ) dut (
    .trn_clk (trn_clk),
    .reset   (reset),
    .bus     (bus.slave)
  );

  always #5 trn_clk = ~trn_clk;

  typedef struct {
    logic        req_n;
    logic [31:0] count;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // Reference model: request outstanding, cycles of holdoff left, pending.
  bit          m_pending;
  bit          m_req;
  int unsigned m_hold;
  logic [31:0] m_count;

  task automatic check(input string name, input int at, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, at, act, exp);
    end
  endtask

  // Monitor: compare whatever the DUT shows against the oldest expectation.
  exp_t e;
  always @(negedge trn_clk) begin
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("cfg_interrupt_n", e.cyc, {31'd0, bus.cfg_interrupt_n}, {31'd0, e.req_n});
      check("irq_count", e.cyc, bus.irq_count, e.count);
      check("cfg_interrupt_assert_n", e.cyc, {31'd0, bus.cfg_interrupt_assert_n}, 32'd1);
      check("cfg_interrupt_di", e.cyc, {24'd0, bus.cfg_interrupt_di}, {24'd0, TB_VECTOR});
    end
  end

  task automatic model_clear();
    m_pending = 1'b0;
    m_req     = 1'b0;
    m_hold    = 0;
    m_count   = '0;
  endtask

  task automatic model_step(input bit ev, input bit en, input bit msi, input bit rdy_n,
                            input logic [31:0] period);
    bit grant;
    bit fire;
    grant = m_req && !rdy_n;
    fire  = (m_pending || ev) && en && msi;
    if (m_req) begin
      if (grant) begin
        m_count = m_count + 32'd1;
        m_req   = 1'b0;
        m_hold  = period;
      end
    end else if (m_hold != 0) begin
      m_hold = m_hold - 1;
    end else if (fire) begin
      m_req = 1'b1;
    end
    if (ev) m_pending = 1'b1;
    else if (grant) m_pending = 1'b0;
  endtask

  // Reset asserted mid-cycle so its effect on the outputs is asynchronous.
  task automatic hold_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge trn_clk);
      #1;
      reset = 1'b1;
      model_clear();
      bus.irq_event = 1'b0;
      sb.push_back('{req_n: 1'b1, count: 32'd0, cyc: cyc});
      cyc++;
    end
  endtask

  task automatic cycle(input bit ev, input bit en, input bit msi, input bit rdy_n,
                       input logic [31:0] period);
    @(posedge trn_clk);
    #1;
    reset = 1'b0;
    sb.push_back('{req_n: !m_req, count: m_count, cyc: cyc});
    bus.irq_event               = ev;
    bus.interrupts_enabled      = en;
    bus.cfg_interrupt_msienable = msi;
    bus.cfg_interrupt_rdy_n     = rdy_n;
    bus.interrupt_period        = period;
    model_step(ev, en, msi, rdy_n, period);
    cyc++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.irq_event               = 1'b0;
    bus.interrupts_enabled      = 1'b0;
    bus.cfg_interrupt_msienable = 1'b0;
    bus.cfg_interrupt_rdy_n     = 1'b1;
    bus.interrupt_period        = c_INTERRUPT_PERIOD_RST;
    model_clear();
    hold_reset(3);

    // Single event, grant three cycles later, period 4.
    for (int i = 0; i < 10; i++) cycle(0, 1, 1, 1, 4);
    cycle(1, 1, 1, 1, 4);
    cycle(0, 1, 1, 1, 4);
    cycle(0, 1, 1, 1, 4);
    cycle(0, 1, 1, 0, 4);
    for (int i = 0; i < 8; i++) cycle(0, 1, 1, 1, 4);

    // Period 100 with five events during holdoff, period changed mid-holdoff.
    cycle(1, 1, 1, 1, 100);
    cycle(0, 1, 1, 0, 100);
    for (int i = 0; i < 110; i++)
      cycle((i % 15 == 3) && (i < 75), 1, 1, 0, (i < 20) ? 100 : 7);
    for (int i = 0; i < 5; i++) cycle(0, 1, 1, 1, 7);

    // Event while disabled, enable after 50 cycles.
    hold_reset(2);
    cycle(1, 0, 1, 1, 3);
    for (int i = 0; i < 50; i++) cycle(0, 0, 1, 1, 3);
    for (int i = 0; i < 3; i++) cycle(0, 1, 1, 1, 3);
    cycle(0, 1, 1, 0, 3);
    for (int i = 0; i < 6; i++) cycle(0, 1, 0, 1, 3);

    // Enable dropped while requesting, grant withheld for 20 cycles.
    cycle(1, 1, 1, 1, 2);
    cycle(0, 1, 1, 1, 2);
    for (int i = 0; i < 20; i++) cycle(0, 0, 0, 1, 2);
    cycle(0, 0, 0, 0, 2);
    for (int i = 0; i < 5; i++) cycle(0, 1, 1, 1, 2);

    // Event on the grant cycle with period 0.
    cycle(1, 1, 1, 1, 0);
    cycle(0, 1, 1, 1, 0);
    cycle(1, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 1, 1, 0);
    cycle(0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 1, 1, 0);

    // Reset mid-ASSERT, then mid-HOLDOFF; nothing must fire afterwards.
    cycle(1, 1, 1, 1, 5);
    cycle(0, 1, 1, 1, 5);
    cycle(0, 1, 1, 1, 5);
    hold_reset(2);
    for (int i = 0; i < 6; i++) cycle(0, 1, 1, 0, 5);
    cycle(1, 1, 1, 1, 9);
    cycle(0, 1, 1, 0, 9);
    cycle(1, 1, 1, 1, 9);
    cycle(0, 1, 1, 1, 9);
    hold_reset(1);
    for (int i = 0; i < 15; i++) cycle(0, 1, 1, 0, 9);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        hold_reset(1);
      end else begin
        cycle($urandom_range(0, 5) == 0,
              $urandom_range(0, 15) != 0,
              $urandom_range(0, 20) != 0,
              $urandom_range(0, 2) != 0,
              ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(1, 6)));
      end
    end
    for (int i = 0; i < 10; i++) cycle(0, 1, 1, 0, 1);

    @(negedge trn_clk);
    #1;
    check("scoreboard_drained", cyc, 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/interrupt_gen.md
INTERRUPT_GEN -- requirements
Module: interrupt_gen

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 MSI_VECTOR, default 8'h00, is the value driven on cfg_interrupt_di.
REQ-003 trn_clk  in  1  PCIe transaction clock; all logic on its rising edge.
REQ-004 reset  in  1  asynchronous active-high reset.
REQ-005 interrupts_enabled  in  1  host interrupt enable from the BAR2 register decoder.
REQ-006 interrupt_period  in  32  holdoff length in trn_clk cycles, from the BAR2 register decoder.
REQ-007 irq_event  in  1  single-cycle pulse from the DMA engines meaning new host-visible data.
REQ-008 cfg_interrupt_msienable  in  1  MSI enabled by the host in config space.
REQ-009 cfg_interrupt_rdy_n  in  1  active-low grant from the PCIe core.
REQ-010 cfg_interrupt_n  out  1  active-low interrupt request to the PCIe core.
REQ-011 cfg_interrupt_assert_n  out  1  legacy INTx assert, held at 1.
REQ-012 cfg_interrupt_di  out  8  MSI vector number, held at MSI_VECTOR.
REQ-013 irq_count  out  32  number of interrupts granted by the core since reset.

Function
REQ-014 A pending flag SHALL be set by irq_event and cleared on the cycle cfg_interrupt_n=0 and cfg_interrupt_rdy_n=0 (grant), unless irq_event is also 1 on that cycle, in which case it stays set.
REQ-015 The FSM SHALL have three states: IDLE, ASSERT and HOLDOFF.
REQ-016 IDLE->ASSERT SHALL occur when (pending or irq_event), interrupts_enabled=1 and cfg_interrupt_msienable=1.
REQ-017 cfg_interrupt_n SHALL go low on the first edge after the REQ-016 condition is true (1-cycle latency from an irq_event sampled in IDLE).
REQ-018 In ASSERT, cfg_interrupt_n SHALL stay low until the grant, even if interrupts_enabled or msienable drops.
REQ-019 On grant, cfg_interrupt_n SHALL return to 1 on the next edge.
REQ-020 On grant, irq_count SHALL increment and wrap from 32'hFFFFFFFF to 0.
REQ-021 On grant, the holdoff counter SHALL load the interrupt_period value sampled on the grant cycle.
REQ-022 On grant, the FSM SHALL go to HOLDOFF, or to IDLE if that period is 0.
REQ-023 HOLDOFF SHALL last exactly interrupt_period cycles, decrementing the counter once per cycle, then go to IDLE.
REQ-024 Changes to interrupt_period during HOLDOFF SHALL not affect the running count.
REQ-025 Events arriving in ASSERT or HOLDOFF SHALL only set pending; they are coalesced into at most one further interrupt.
REQ-026 Events arriving while interrupts_enabled=0 or msienable=0 SHALL be kept pending and fire once enable returns.
REQ-027 An irq_event asserted on the same cycle the FSM enters IDLE from HOLDOFF SHALL be treated as pending; the FSM enters ASSERT on the following cycle.

Reset
REQ-028 Reset SHALL force, asynchronously: state=IDLE, pending=0, holdoff counter=0, irq_count=0, cfg_interrupt_n=1, cfg_interrupt_assert_n=1, cfg_interrupt_di=MSI_VECTOR.
REQ-029 Reset asserted during ASSERT SHALL immediately deassert cfg_interrupt_n; the request is lost and not replayed.

Structure
REQ-030 The FSM state encodings (one-hot, 8-bit, matching the team's register decoders) SHALL live in the shared engine package.
REQ-031 The shared engine package SHALL also hold the interrupt-period reset value 32'h3D090.
REQ-032 The holdoff down-counter SHALL be a sub-module irq_holdoff_cnt with ports load, load_value[31:0], busy and done.

Verification
REQ-033 Enabled, period=4, single irq_event at cycle 10, rdy_n low at cycle 13 -> cfg_interrupt_n low for cycles 11-13 and high at 14; irq_count=1; FSM back in IDLE at cycle 18.
REQ-034 Period=100, 5 irq_events during HOLDOFF -> exactly one further interrupt, requested on the cycle after HOLDOFF ends; irq_count=2.
REQ-035 interrupts_enabled=0 and irq_event, then enable after 50 cycles -> no request while disabled, cfg_interrupt_n low one cycle after enable.
REQ-036 interrupts_enabled dropped while cfg_interrupt_n is low and rdy_n held high for 20 cycles -> cfg_interrupt_n stays low until rdy_n=0, then high; irq_count increments.
REQ-037 irq_event on the grant cycle with period=0 -> pending stays set, a second request follows with no holdoff, irq_count=2.
REQ-038 Reset pulsed mid-ASSERT and mid-HOLDOFF -> all outputs at reset values immediately, no spurious request after release.
